// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode and state encodings for the LED sequencer
package led_seq_pkg;

  // Run modes, latched on the IDLE to run transition
  localparam logic [1:0] MODE_FWD  = 2'b00;
  localparam logic [1:0] MODE_BWD  = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_FILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_FWD = 2'd1,
    ST_RUN_BWD = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides the clock into position-step ticks while a run is active
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The tick is the terminal count; with TICK_DIV = 1 it fires every run cycle
  assign tick = run && (cnt_q == CNT_LAST);

  // Next count: restart on clear, outside a run, and after every tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer with forward, backward, ping-pong and fill runs
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS   = 8,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] POS_LAST   = PW'(N_LEDS - 1);
  localparam logic [PW:0]   STEP_W     = (PW + 1)'(STEP);
  localparam logic [PW-1:0] PING_START = (N_LEDS - 1 > STEP) ? PW'(N_LEDS - 1 - STEP) : '0;
  localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_ONES = '1;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              run;
  logic              clr;
  logic              tick;
  logic [PW:0]       pos_sum;
  logic [PW:0]       pos_diff;

  // Fill lights bits 0..p; every other mode lights only bit p
  function automatic logic [N_LEDS-1:0] pattern(input logic [PW-1:0] p, input logic [1:0] m);
    if (m == MODE_FILL) begin
      return ~(LED_ONES << ({1'b0, p} + (PW + 1)'(1)));
    end
    return LED_ONE << p;
  endfunction

  assign run  = (state_q == ST_RUN_FWD) || (state_q == ST_RUN_BWD);
  assign clr  = (state_q == ST_IDLE) || !en;

  // One extra bit so overshoot (sum) and underflow (borrow in diff) are visible before clamping
  assign pos_sum  = {1'b0, pos_q} + STEP_W;
  assign pos_diff = {1'b0, pos_q} - STEP_W;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .run   (run),
    .tick  (tick)
  );

  // Next-state, position and registered-output logic; en low overrides everything
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    mode_d  = mode_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (!en) begin
      state_d = ST_IDLE;
      pos_d   = '0;
      leds_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d = mode;
          busy_d = 1'b1;
          if (mode == MODE_BWD) begin
            state_d = ST_RUN_BWD;
            pos_d   = POS_LAST;
          end else begin
            state_d = ST_RUN_FWD;
            pos_d   = '0;
          end
        end
        ST_RUN_FWD: begin
          if (tick) begin
            if (pos_q == POS_LAST) begin
              if (mode_q == MODE_PING) begin
                state_d = ST_RUN_BWD;
                pos_d   = PING_START;
              end else begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else if (pos_sum > {1'b0, POS_LAST}) begin
              pos_d = POS_LAST;
            end else begin
              pos_d = pos_sum[PW-1:0];
            end
          end
        end
        ST_RUN_BWD: begin
          if (tick) begin
            if (pos_q == '0) begin
              state_d = ST_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (pos_diff[PW]) begin
              pos_d = '0;
            end else begin
              pos_d = pos_diff[PW-1:0];
            end
          end
        end
        default: begin
          state_d = ST_DONE;
        end
      endcase

      // Pattern tracks the position on the same edge; DONE keeps the final pattern
      if ((state_d == ST_RUN_FWD) || (state_d == ST_RUN_BWD)) begin
        leds_d = pattern(pos_d, mode_d);
      end
    end
  end

  // State, position and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      mode_q  <= MODE_FWD;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - randomized self-checking bench for led_sequencer against a run-list model
module tb_led_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;

  logic [7:0] leds_a, leds_b, leds_d;
  logic [3:0] leds_c;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;

  int checks   = 0;
  int failures = 0;

  // Model state: whether a run is active, edges since E0, latched mode
  bit         active   = 0;
  int         k        = 0;
  logic [1:0] mode_lat = 2'b00;
  int         rst_cnt  = 0;
  int         rst_seen = 0;

  led_sequencer #(.N_LEDS(8), .STEP(1), .TICK_DIV(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_a), .busy(busy_a), .done(done_a));
  led_sequencer #(.N_LEDS(8), .STEP(3), .TICK_DIV(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_b), .busy(busy_b), .done(done_b));
  led_sequencer #(.N_LEDS(4), .STEP(1), .TICK_DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_c), .busy(busy_c), .done(done_c));
  led_sequencer #(.N_LEDS(8), .STEP(2), .TICK_DIV(3)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .leds(leds_d), .busy(busy_d), .done(done_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs k edges after E0: build the list of positions a run visits,
  // each held for d cycles, then the last pattern with done set
  function automatic void model_out(input int n, input int s, input int d, input logic [1:0] m,
                                    input int kk, output logic [7:0] l, output logic b, output logic dn);
    int seq[$];
    int p;
    int idx;
    int pos;
    p = (m == 2'b01) ? n - 1 : 0;
    seq.push_back(p);
    if (m != 2'b01) begin
      while (p != n - 1) begin
        p = (p + s > n - 1) ? n - 1 : p + s;
        seq.push_back(p);
      end
    end
    if (m == 2'b10) begin
      p = (n - 1 - s < 0) ? 0 : n - 1 - s;
      seq.push_back(p);
    end
    if (m == 2'b01 || m == 2'b10) begin
      while (p != 0) begin
        p = (p - s < 0) ? 0 : p - s;
        seq.push_back(p);
      end
    end
    idx = kk / d;
    if (idx < seq.size()) begin
      pos = seq[idx];
      b   = 1'b1;
      dn  = 1'b0;
    end else begin
      pos = seq[seq.size() - 1];
      b   = 1'b0;
      dn  = 1'b1;
    end
    l = (m == 2'b11) ? 8'((1 << (pos + 1)) - 1) : 8'(1 << pos);
  endfunction

  task automatic check_one(input string name, input int n, input int s, input int d,
                           input logic [7:0] l, input logic b, input logic dn);
    logic [7:0] el;
    logic       eb;
    logic       ed;
    if (active) begin
      model_out(n, s, d, mode_lat, k, el, eb, ed);
    end else begin
      el = 8'h00;
      eb = 1'b0;
      ed = 1'b0;
    end
    chk({name, "_leds"}, 32'(l), 32'(el));
    chk({name, "_busy"}, 32'(b), 32'(eb));
    chk({name, "_done"}, 32'(dn), 32'(ed));
  endtask

  // Model advance on each edge, then compare all instances just after it
  always @(posedge clk) begin
    if (rst_cnt != rst_seen) begin
      active   = 0;
      rst_seen = rst_cnt;
    end
    if (!rst_n || !en) begin
      active = 0;
      k      = 0;
    end else if (!active) begin
      active   = 1;
      k        = 0;
      mode_lat = mode;
    end else begin
      k++;
    end
    #1;
    check_one("a", 8, 1, 1, leds_a, busy_a, done_a);
    check_one("b", 8, 3, 2, leds_b, busy_b, done_b);
    check_one("c", 4, 1, 1, {4'h0, leds_c}, busy_c, done_c);
    check_one("d", 8, 2, 3, leds_d, busy_d, done_d);
  end

  // Asynchronous reset pulse between edges; outputs must clear before any clock edge
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    rst_cnt++;
    #1;
    chk("rst_leds_a", 32'(leds_a), 32'h0);
    chk("rst_leds_b", 32'(leds_b), 32'h0);
    chk("rst_leds_c", 32'(leds_c), 32'h0);
    chk("rst_leds_d", 32'(leds_d), 32'h0);
    chk("rst_busy", 32'({busy_a, busy_b, busy_c, busy_d}), 32'h0);
    chk("rst_done", 32'({done_a, done_b, done_c, done_d}), 32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int len;
    int gap;
    int rst_at;
    bit do_rst;

    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Forward run held into DONE, then reset while in DONE
    en   = 1'b1;
    mode = 2'b00;
    repeat (12) @(negedge clk);
    pulse_reset();
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    // en dropped early in a forward run, then restarted
    en = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    // Ping-pong with mode toggling mid-run
    en   = 1'b1;
    mode = 2'b10;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      mode = ~mode;
    end
    en = 1'b0;
    @(negedge clk);

    // Randomized runs: mode, length, mid-run mode changes, occasional async reset
    for (int r = 0; r < 80; r++) begin
      mode   = 2'($urandom_range(0, 3));
      en     = 1'b1;
      len    = $urandom_range(1, 40);
      do_rst = ($urandom_range(0, 5) == 0);
      rst_at = $urandom_range(0, len - 1);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
        if (do_rst && i == rst_at) pulse_reset();
      end
      en  = 1'b0;
      gap = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
